// File: rtl/mem_bus_arbiter_if.sv
// Bus arbitration handshake bundle: active-low requests/grants from four masters
// plus the registered owner index, busy flag and preempt pulse back to the bus.
interface mem_bus_arbiter_if;
  logic [3:0] m_req_;
  logic [3:0] m_grnt_;
  logic [1:0] owner;
  logic       busy;
  logic       preempt;

  modport master (
    output m_req_,
    input  m_grnt_,
    input  owner,
    input  busy,
    input  preempt
  );

  modport slave (
    input  m_req_,
    output m_grnt_,
    output owner,
    output busy,
    output preempt
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Four-master round-robin bus arbiter with registered grants and owner index.
// Optional hold-timeout preemption is enabled by defining BUS_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int HOLD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q;
  logic [1:0]          last_q;
  logic [1:0]          owner_q;
  logic [3:0]          grnt_q;
  logic                busy_q;
  logic                preempt_q;
  logic [HOLD_W-1:0]   hold_cnt_q;

  logic [3:0]          req;
  logic [2:0]          idle_pick;
  logic [2:0]          rel_pick;

  // Returns {found, index} of the first set mask bit at or after start, wrapping.
  function automatic logic [2:0] rr_pick(input logic [1:0] start, input logic [3:0] mask);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign req       = ~bus.m_req_;
  assign idle_pick = rr_pick(last_q + 2'd1, req);
  // The owner has released here, so its own bit is already clear in req.
  assign rel_pick  = rr_pick(owner_q + 2'd1, req);

`ifdef BUS_ARB_TIMEOUT_EN
  logic [3:0] other_req;
  logic [2:0] pre_pick;
  assign other_req = req & ~(4'b0001 << owner_q);
  assign pre_pick  = rr_pick(owner_q + 2'd1, other_req);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= 2'd3;
      owner_q    <= 2'd0;
      grnt_q     <= 4'b1111;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (idle_pick[2]) begin
            state_q    <= GRANT;
            owner_q    <= idle_pick[1:0];
            last_q     <= idle_pick[1:0];
            grnt_q     <= ~(4'b0001 << idle_pick[1:0]);
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
          end
        end
        GRANT: begin
          if (req[owner_q]) begin
`ifdef BUS_ARB_TIMEOUT_EN
            if ((hold_cnt_q == HOLD_W'(HOLD_MAX)) && pre_pick[2]) begin
              owner_q    <= pre_pick[1:0];
              last_q     <= pre_pick[1:0];
              grnt_q     <= ~(4'b0001 << pre_pick[1:0]);
              preempt_q  <= 1'b1;
              hold_cnt_q <= '0;
            end else if (hold_cnt_q != HOLD_W'(HOLD_MAX)) begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
`else
            if (hold_cnt_q != HOLD_W'(HOLD_MAX)) hold_cnt_q <= hold_cnt_q + 1'b1;
`endif
          end else if (rel_pick[2]) begin
            owner_q    <= rel_pick[1:0];
            last_q     <= rel_pick[1:0];
            grnt_q     <= ~(4'b0001 << rel_pick[1:0]);
            hold_cnt_q <= '0;
          end else begin
            state_q    <= IDLE;
            grnt_q     <= 4'b1111;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m_grnt_ = grnt_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, rotation, idle path, reset mid-grant,
// hold/timeout behaviour (both BUS_ARB_TIMEOUT_EN builds) and back-to-back tenures.
module tb_mem_bus_arbiter;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HOLD_MAX_TB = 4;
`else
  localparam int HOLD_MAX_TB = 16;
`endif

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.HOLD_MAX(HOLD_MAX_TB), .HOLD_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are examined 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic [3:0] g, input logic [1:0] o,
                           input logic b, input logic p);
    check_eq({tag, ".grnt"},    32'(bus.m_grnt_), 32'(g));
    check_eq({tag, ".owner"},   32'(bus.owner),   32'(o));
    check_eq({tag, ".busy"},    32'(bus.busy),    32'(b));
    check_eq({tag, ".preempt"}, 32'(bus.preempt), 32'(p));
  endtask

  initial begin
    logic [1:0] order [5];
    logic [3:0] rq;
    n_tests = 0;
    n_fail  = 0;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

    // Reset held with all requesting
    reset = 1'b0;
    bus.m_req_ = 4'b0000;
    repeat (3) step();
    check_bus("reset", 4'b1111, 2'd0, 1'b0, 1'b0);

    // First grant after reset goes to master 0, then round robin 0,1,2,3,0
    reset = 1'b1;
    step();
    for (int t = 0; t < 5; t++) begin
      check_bus($sformatf("rr%0d", t), ~(4'b0001 << order[t]), order[t], 1'b1, 1'b0);
      bus.m_req_ = 4'b0000;
      step();
      check_eq($sformatf("rr%0d.hold", t), 32'(bus.owner), 32'(order[t]));
      rq = 4'b0000;
      rq[order[t]] = 1'b1;
      bus.m_req_ = (t == 4) ? 4'b1111 : rq;
      step();
    end
    check_bus("rr_idle", 4'b1111, 2'd0, 1'b0, 1'b0);

    // Rotation: 1 granted, releases while 3 requests, then 3 releases with 0 and 2 waiting
    bus.m_req_ = 4'b1101;
    step();
    check_bus("rot_own1", 4'b1101, 2'd1, 1'b1, 1'b0);
    bus.m_req_ = 4'b0111;
    step();
    check_bus("rot_own3", 4'b0111, 2'd3, 1'b1, 1'b0);
    bus.m_req_ = 4'b1010;
    step();
    check_bus("rot_own0", 4'b1110, 2'd0, 1'b1, 1'b0);
    bus.m_req_ = 4'b1011;
    step();
    check_bus("rot_own2", 4'b1011, 2'd2, 1'b1, 1'b0);
    bus.m_req_ = 4'b1111;
    step();
    check_bus("rot_idle", 4'b1111, 2'd2, 1'b0, 1'b0);

    // Idle path: master 2 alone for 5 cycles
    for (int c = 0; c < 5; c++) begin
      bus.m_req_ = 4'b1011;
      step();
      check_bus($sformatf("idle_g%0d", c), 4'b1011, 2'd2, 1'b1, 1'b0);
    end
    bus.m_req_ = 4'b1111;
    step();
    check_bus("idle_rel", 4'b1111, 2'd2, 1'b0, 1'b0);

    // Reset mid-grant
    bus.m_req_ = 4'b1101;
    step();
    check_bus("rmid_own1", 4'b1101, 2'd1, 1'b1, 1'b0);
    reset = 1'b0;
    step();
    check_bus("rmid_rst", 4'b1111, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
    bus.m_req_ = 4'b1001;
    step();
    check_bus("rmid_after", 4'b1101, 2'd1, 1'b1, 1'b0);
    bus.m_req_ = 4'b1111;
    step();
    check_bus("rmid_idle", 4'b1111, 2'd1, 1'b0, 1'b0);

    // Hold / timeout: master 0 keeps requesting, master 1 joins at grant cycle 1
    bus.m_req_ = 4'b1110;
    step();
    check_bus("to_g0", 4'b1110, 2'd0, 1'b1, 1'b0);
    bus.m_req_ = 4'b1100;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      step();
      check_bus($sformatf("to_hold%0d", c), 4'b1110, 2'd0, 1'b1, 1'b0);
    end
    step();
    check_bus("to_preempt", 4'b1101, 2'd1, 1'b1, 1'b1);
    step();
    check_bus("to_after", 4'b1101, 2'd1, 1'b1, 1'b0);
`else
    for (int c = 1; c <= 8; c++) begin
      step();
      check_bus($sformatf("to_hold%0d", c), 4'b1110, 2'd0, 1'b1, 1'b0);
    end
    bus.m_req_ = 4'b1101;
    step();
    check_bus("to_release", 4'b1101, 2'd1, 1'b1, 1'b0);
`endif
    bus.m_req_ = 4'b1111;
    step();
    check_bus("to_idle", 4'b1111, 2'd1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
